instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch initiator for the pipelined core. Holds the program counter, drives the address and chip select of the combinational-read instruction memory, and captures the returned words with their PCs into a small FIFO. Decode drains the FIFO through a valid/ready handshake, and execute redirects fetch on taken branches and jumps.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `DEPTH`, default `2`: fetch FIFO entries. Power of two, 2..8.

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `fetch_en`  in  1  global fetch enable; low stalls issue without losing state.
- `iaddr`  out  32  byte address to instruction memory; always equals the PC register.
- `cs_n`  out  1  active-low memory select; low only in issue cycles.
- `instrCode`  in  32  memory read data, valid in the same cycle as `iaddr`.
- `redirect_valid`  in  1  redirect request from execute.
- `redirect_pc`  in  32  redirect target.
- `out_valid`  out  1  FIFO head valid.
- `out_instr`  out  32  head instruction.
- `out_pc`  out  32  head PC.
- `out_ready`  in  1  decode accepts the head this cycle.
- `misalign_trap`  out  1  misaligned redirect target; see Configuration.

## Operation
- State machine: FETCH and TRAP. Reset enters FETCH. TRAP exists only with the macro.
- `pop = out_valid & out_ready`.
- `issue = FETCH & fetch_en & ~redirect_valid & (count < DEPTH | pop)`.
- `cs_n = ~issue`.
- On issue: push `{pc, instrCode}` at the FIFO tail and set `pc <= pc + 4`.
- PC arithmetic is modulo 2^32: `32'hFFFF_FFFC` is followed by `32'h0000_0000`.
- FIFO occupancy `count` is `$clog2(DEPTH)+1` bits wide.
  - Push only: `count + 1`. Pop only: `count - 1`. Push and pop together: `count` unchanged.
  - Read and write pointers wrap modulo `DEPTH`.
- `out_valid = (count != 0)`. `out_instr` and `out_pc` come from the head entry and are registered storage, not combinational from `instrCode`.
- Redirect has priority over everything else in its cycle:
  - Flush the FIFO (`count <= 0`, pointers reset).
  - No issue.
  - A pop in the same cycle is still counted by decode, but flushed state wins.
  - `pc <= redirect_pc`.
- With `fetch_en` low: no issue and PC holds. Pops continue.
- Head stability: while `out_valid & ~out_ready`, the head entry must not change.

## Timing
- Reset values:
  - `pc = RESET_PC`, so `iaddr = RESET_PC`.
  - `cs_n = 1`, `out_valid = 0`, `out_instr = 0`, `out_pc = 0`, `misalign_trap = 0`, `count = 0`, state FETCH.
- Reset asserted mid-operation discards the FIFO contents and the PC immediately (asynchronous).
- The first issue happens in the first cycle after reset deassertion with `fetch_en` high.
- Issue-to-output latency is 1 cycle: a word issued in cycle N is visible at the head in cycle N+1 if the FIFO was empty.
- Redirect in cycle N:
  - `out_valid = 0` in N+1.
  - Target issued in N+1.
  - Target at the head in N+2.
- Full FIFO with `out_ready` high: issue continues at 1 word/cycle.
- Sustained throughput is 1 instruction/cycle with `out_ready` tied high.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` is still accepted: flush, `pc <= redirect_pc`.
  - The state goes to TRAP and `misalign_trap` rises the next cycle.
  - In TRAP, `issue = 0`.
  - TRAP is left only by reset or by an aligned redirect, which returns to FETCH and clears `misalign_trap` the next cycle.
- Not defined:
  - `redirect_pc[1:0]` is ignored and the PC loads `{redirect_pc[31:2], 2'b00}`.
  - `misalign_trap` is tied to 0.
  - No TRAP state.

## Test plan
- Reset, then release with memory words at 0x0/0x4/0x8 = 0x00500093/0x00A00113/0x002081B3 and `out_ready=1` -> `out_pc` 0x0, 0x4, 0x8 on consecutive cycles starting one cycle after release, with matching `out_instr`.
- `out_ready=0` for 5 cycles -> `count` stops at `DEPTH`, `cs_n=1` once full, head stays `pc=0x0`, and `iaddr` holds at `0x0+4*DEPTH`.
- Redirect to 0x100 while the FIFO holds 2 entries -> `out_valid=0` the next cycle, then `out_pc=0x100` two cycles after the redirect, with no stale entry ever popped.
- FIFO full with `out_ready=1` continuously -> one pop and one push per cycle, `count` constant at `DEPTH`, and PCs strictly increasing by 4.
- Redirect to 0xFFFF_FFF8 -> `out_pc` sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Redirect to 0x102:
  - Macro on: `misalign_trap=1` the next cycle and `cs_n` stays high until a redirect to 0x200 clears it.
  - Macro off: fetch proceeds from 0x100.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, instruction-memory request, fetch FIFO to decode.
// Ports: clk/rst, fetch_en, iaddr/cs_n/instrCode memory side,
//   redirect_valid/redirect_pc from execute, out_valid/out_instr/out_pc/
//   out_ready to decode, misalign_trap.
// Optional: define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirects.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] iaddr,
  output logic        cs_n,
  input  logic [31:0] instrCode,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        misalign_trap
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic {FETCH = 1'b0, TRAP = 1'b1} state_e;
`else
  typedef enum logic {FETCH = 1'b0} state_e;
`endif

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_pc_q    [DEPTH];
  logic [31:0]   mem_instr_q [DEPTH];

  logic          pop;
  logic          issue;
  logic [31:0]   redir_tgt;
  state_e        redir_state;

  assign iaddr     = pc_q;
  assign cs_n      = ~issue;
  assign out_valid = (count_q != '0);
  assign out_pc    = mem_pc_q[rd_ptr_q];
  assign out_instr = mem_instr_q[rd_ptr_q];

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_tgt     = redirect_pc;
  assign redir_state   = (redirect_pc[1:0] != 2'b00) ? TRAP : FETCH;
  assign misalign_trap = (state_q == TRAP);
`else
  // Low address bits are dropped: targets are forced word aligned.
  logic unused_redir_lo;
  assign unused_redir_lo = ^redirect_pc[1:0];
  assign redir_tgt       = {redirect_pc[31:2], 2'b00};
  assign redir_state     = FETCH;
  assign misalign_trap   = 1'b0;
`endif

  always_comb begin
    pop   = out_valid & out_ready;
    issue = (state_q == FETCH) & fetch_en & ~redirect_valid
          & ((count_q < DEPTH_C) | pop);
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_valid) begin
      // Flush wins over any same-cycle pop.
      state_d  = redir_state;
      pc_d     = redir_tgt;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (issue) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({issue, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else if (issue) begin
      mem_pc_q[wr_ptr_q]    <= pc_q;
      mem_instr_q[wr_ptr_q] <= instrCode;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed stimulus, queue-based reference model
// checked every cycle, plus literal expectations from the test plan.
module tb_instr_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] iaddr;
  logic        cs_n;
  logic [31:0] instrCode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        misalign_trap;

  int n_chk  = 0;
  int n_fail = 0;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .fetch_en(fetch_en),
    .iaddr(iaddr),
    .cs_n(cs_n),
    .instrCode(instrCode),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_ready(out_ready),
    .misalign_trap(misalign_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0020_81B3;
      default: return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign instrCode = memword(iaddr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      q[$];
  logic [31:0] m_pc   = RESET_PC;
  logic        m_trap = 1'b0;

  function automatic logic m_issue();
    logic p;
    p = (q.size() != 0) && out_ready;
    return !m_trap && fetch_en && !redirect_valid
        && ((q.size() < DEPTH) || p);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_pc   = RESET_PC;
      m_trap = 1'b0;
    end else if (redirect_valid) begin
      q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      m_pc   = redirect_pc;
      m_trap = (redirect_pc % 4) != 0;
`else
      m_pc   = redirect_pc & ~32'd3;
`endif
    end else begin
      logic iss;
      iss = m_issue();
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (iss) begin
        q.push_back('{pc: m_pc, instr: memword(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_cs_n", {31'b0, cs_n}, {31'b0, !m_issue()});
      chk("m_iaddr", iaddr, m_pc);
      chk("m_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      chk("m_trap", {31'b0, misalign_trap}, {31'b0, m_trap});
      if (q.size() != 0) begin
        chk("m_out_pc", out_pc, q[0].pc);
        chk("m_out_instr", out_instr, q[0].instr);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prev;

  initial begin
    rst = 1'b1;
    fetch_en = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_iaddr", iaddr, RESET_PC);
    chk("rst_cs_n", {31'b0, cs_n}, 32'd1);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_trap", {31'b0, misalign_trap}, 32'd0);

    cyc();
    rst = 1'b0;
    fetch_en = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("first_cs_n", {31'b0, cs_n}, 32'd0);
    chk("first_iaddr", iaddr, 32'h0);
    @(negedge clk);
    chk("seq0_pc", out_pc, 32'h0);
    chk("seq0_in", out_instr, 32'h0050_0093);
    @(negedge clk);
    chk("seq1_pc", out_pc, 32'h4);
    chk("seq1_in", out_instr, 32'h00A0_0113);
    @(negedge clk);
    chk("seq2_pc", out_pc, 32'h8);
    chk("seq2_in", out_instr, 32'h0020_81B3);

    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    cyc();
    redirect_valid = 1'b0;
    repeat (5) cyc();
    @(negedge clk);
    chk("full_cs_n", {31'b0, cs_n}, 32'd1);
    chk("full_iaddr", iaddr, 32'(4 * DEPTH));
    chk("full_head", out_pc, 32'h0);

    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    out_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rd_valid0", {31'b0, out_valid}, 32'd0);
    chk("rd_iaddr", iaddr, 32'h100);
    @(negedge clk);
    chk("rd_head", out_pc, 32'h100);

    cyc();
    out_ready = 1'b0;
    repeat (3) cyc();
    out_ready = 1'b1;
    @(negedge clk);
    prev = out_pc;
    repeat (6) begin
      @(negedge clk);
      chk("thru_pc", out_pc, prev + 32'd4);
      chk("thru_cs_n", {31'b0, cs_n}, 32'd0);
      prev = out_pc;
    end

    cyc();
    fetch_en = 1'b0;
    out_ready = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("stall_cs_n", {31'b0, cs_n}, 32'd1);
    cyc();
    fetch_en = 1'b1;
    out_ready = 1'b1;

    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wrap0", out_pc, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap1", out_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap2", out_pc, 32'h0000_0000);

    cyc();
    rst = 1'b1;
    #1;
    chk("arst_iaddr", iaddr, RESET_PC);
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    cyc();
    rst = 1'b0;
    repeat (2) cyc();

    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_trap", {31'b0, misalign_trap}, 32'd1);
    chk("mis_cs_n", {31'b0, cs_n}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("mis_hold", {31'b0, cs_n}, 32'd1);
    end
    cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    cyc();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("mis_clr", {31'b0, misalign_trap}, 32'd0);
    chk("mis_cs_n2", {31'b0, cs_n}, 32'd0);
    chk("mis_iaddr", iaddr, 32'h200);
`else
    chk("mis_iaddr", iaddr, 32'h100);
    chk("mis_cs_n", {31'b0, cs_n}, 32'd0);
    chk("mis_trap", {31'b0, misalign_trap}, 32'd0);
    @(negedge clk);
    chk("mis_head", out_pc, 32'h100);
`endif

    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
